// File: rtl/comporta_pkg.sv
// rtl/comporta_pkg.sv - shared state encodings for the floodgate control unit
//
// Purpose: state codes of the comporta_uc_param FSM. The state register value
// is the dbEstado debug code, so the 7-segment decoder can reuse the same
// constants. Codes 10..15 are never produced by a legal state.
package comporta_pkg;

   localparam int ST_W = 4;

   typedef logic [ST_W-1:0] estado_t;

   localparam estado_t ST_INICIAL      = 4'd0;
   localparam estado_t ST_PREPARA      = 4'd1;
   localparam estado_t ST_ABRE_PASSO   = 4'd2;
   localparam estado_t ST_ESPERA_ABRE  = 4'd3;
   localparam estado_t ST_ABERTA       = 4'd4;
   localparam estado_t ST_FECHA_PASSO  = 4'd5;
   localparam estado_t ST_ESPERA_FECHA = 4'd6;
   localparam estado_t ST_EMERG_PASSO  = 4'd7;
   localparam estado_t ST_ESPERA_EMERG = 4'd8;
   localparam estado_t ST_TRAVADA      = 4'd9;

   // Any step or wait state: the gate is in motion.
   function automatic logic em_movimento(input estado_t s);
      return (s inside {ST_ABRE_PASSO, ST_ESPERA_ABRE, ST_FECHA_PASSO,
                        ST_ESPERA_FECHA, ST_EMERG_PASSO, ST_ESPERA_EMERG});
   endfunction

   // Emergency closing or latched after an emergency.
   function automatic logic em_alarme(input estado_t s);
      return (s inside {ST_EMERG_PASSO, ST_ESPERA_EMERG, ST_TRAVADA});
   endfunction

endpackage

// File: rtl/comporta_timer.sv
// rtl/comporta_timer.sv - step-interval up-counter with normal and fast terminal counts
//
// Purpose: counts wait cycles inside one gate step.
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous active-low reset
//   clr_i            in   synchronous clear (has priority over en_i)
//   en_i             in   increment by one this cycle
//   fim_intervalo_o  out  count == INTERVAL-1
//   fim_rapido_o     out  count == FAST_INTERVAL-1
module comporta_timer #(
   parameter int unsigned INTERVAL      = 50000000,
   parameter int unsigned FAST_INTERVAL = 12500000,
   parameter int unsigned INT_W         = 26
) (
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic fim_intervalo_o,
   output logic fim_rapido_o
);

   logic [INT_W-1:0] timer_q;
   logic [INT_W-1:0] timer_d;

   always_comb begin
      timer_d = timer_q;
      if (clr_i) begin
         timer_d = '0;
      end else if (en_i) begin
         timer_d = timer_q + INT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign fim_intervalo_o = (timer_q == INT_W'(INTERVAL - 1));
   assign fim_rapido_o    = (timer_q == INT_W'(FAST_INTERVAL - 1));

endmodule

// File: rtl/comporta_uc_param.sv
// rtl/comporta_uc_param.sv - parametrised floodgate control unit with emergency close
//
// Purpose: open/hold/close cycle with reversal, plus a latched emergency close
// at a faster step rate. Owns the position register and FSM; the step timer
// lives in comporta_timer.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   abrirComporta  in   level, high requests the gate open
//   emergencia     in   level, high forces an emergency close
//   posicao        out  current gate position (0 = closed)
//   aberta         out  state is ABERTA
//   fechada        out  posicao == 0
//   movendo        out  any step or wait state
//   alarme         out  emergency step/wait or TRAVADA
//   dbEstado       out  state code for the debug display
module comporta_uc_param
   import comporta_pkg::*;
#(
   parameter int unsigned N_POS         = 4,
   parameter int unsigned POS_W         = 2,
   parameter int unsigned INTERVAL      = 50000000,
   parameter int unsigned FAST_INTERVAL = 12500000,
   parameter int unsigned INT_W         = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             abrirComporta,
   input  logic             emergencia,
   output logic [POS_W-1:0] posicao,
   output logic             aberta,
   output logic             fechada,
   output logic             movendo,
   output logic             alarme,
   output logic [3:0]       dbEstado
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);

   estado_t          estado_q;
   estado_t          estado_d;
   logic [POS_W-1:0] posicao_q;
   logic [POS_W-1:0] posicao_d;

   logic timer_clr;
   logic timer_en;
   logic fim_intervalo;
   logic fim_rapido;

   // Every step state restarts the wait so each step has a fixed length.
   assign timer_clr = (estado_q inside {ST_PREPARA, ST_ABRE_PASSO,
                                        ST_FECHA_PASSO, ST_EMERG_PASSO});
   assign timer_en  = (estado_q inside {ST_ESPERA_ABRE, ST_ESPERA_FECHA,
                                        ST_ESPERA_EMERG});

   comporta_timer #(
      .INTERVAL      (INTERVAL),
      .FAST_INTERVAL (FAST_INTERVAL),
      .INT_W         (INT_W)
   ) u_timer (
      .clock           (clock),
      .reset           (reset),
      .clr_i           (timer_clr),
      .en_i            (timer_en),
      .fim_intervalo_o (fim_intervalo),
      .fim_rapido_o    (fim_rapido)
   );

   always_comb begin
      estado_d  = estado_q;
      posicao_d = posicao_q;
      case (estado_q)
         ST_INICIAL: begin
            if (emergencia) begin
               estado_d = ST_TRAVADA;
            end else if (abrirComporta) begin
               estado_d = ST_PREPARA;
            end
         end
         ST_PREPARA: begin
            estado_d = ST_ABRE_PASSO;
         end
         ST_ABRE_PASSO: begin
            estado_d = ST_ESPERA_ABRE;
            // The FSM never opens past the top, but keep the register bounded.
            if (posicao_q != POS_MAX) begin
               posicao_d = posicao_q + POS_W'(1);
            end
         end
         ST_ESPERA_ABRE: begin
            if (emergencia) begin
               estado_d = ST_EMERG_PASSO;
            end else if (fim_intervalo) begin
               if (posicao_q == POS_MAX) begin
                  estado_d = ST_ABERTA;
               end else if (!abrirComporta) begin
                  estado_d = ST_FECHA_PASSO;
               end else begin
                  estado_d = ST_ABRE_PASSO;
               end
            end
         end
         ST_ABERTA: begin
            if (emergencia) begin
               estado_d = ST_EMERG_PASSO;
            end else if (!abrirComporta) begin
               estado_d = ST_FECHA_PASSO;
            end
         end
         ST_FECHA_PASSO: begin
            estado_d = ST_ESPERA_FECHA;
            if (posicao_q != '0) begin
               posicao_d = posicao_q - POS_W'(1);
            end
         end
         ST_ESPERA_FECHA: begin
            if (emergencia) begin
               estado_d = ST_EMERG_PASSO;
            end else if (fim_intervalo) begin
               if (posicao_q == '0) begin
                  estado_d = ST_INICIAL;
               end else if (abrirComporta) begin
                  estado_d = ST_ABRE_PASSO;
               end else begin
                  estado_d = ST_FECHA_PASSO;
               end
            end
         end
         ST_EMERG_PASSO: begin
            estado_d = ST_ESPERA_EMERG;
            // Emergency can start from position 0 (e.g. mid close), so saturate.
            if (posicao_q != '0) begin
               posicao_d = posicao_q - POS_W'(1);
            end
         end
         ST_ESPERA_EMERG: begin
            if (fim_rapido) begin
               estado_d = (posicao_q == '0) ? ST_TRAVADA : ST_EMERG_PASSO;
            end
         end
         ST_TRAVADA: begin
            // Operator must drop the open request too, so the gate does not
            // reopen straight after the emergency is cleared.
            if (!emergencia && !abrirComporta) begin
               estado_d = ST_INICIAL;
            end
         end
         default: begin
            estado_d = ST_INICIAL;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= ST_INICIAL;
         posicao_q <= '0;
      end else begin
         estado_q  <= estado_d;
         posicao_q <= posicao_d;
      end
   end

   assign posicao  = posicao_q;
   assign aberta   = (estado_q == ST_ABERTA);
   assign fechada  = (posicao_q == '0);
   assign movendo  = em_movimento(estado_q);
   assign alarme   = em_alarme(estado_q);
   assign dbEstado = estado_q;

endmodule

// File: tb/tb_comporta_uc_param.sv
// tb/tb_comporta_uc_param.sv - scoreboard bench for comporta_uc_param
module tb_comporta_uc_param;

   localparam int N_POS    = 4;
   localparam int POS_W    = 2;
   localparam int INTERVAL = 4;
   localparam int FAST     = 2;
   localparam int INT_W    = 3;

   logic             clock;
   logic             reset;
   logic             abrirComporta;
   logic             emergencia;
   logic [POS_W-1:0] posicao;
   logic             aberta;
   logic             fechada;
   logic             movendo;
   logic             alarme;
   logic [3:0]       dbEstado;

   comporta_uc_param #(
      .N_POS         (N_POS),
      .POS_W         (POS_W),
      .INTERVAL      (INTERVAL),
      .FAST_INTERVAL (FAST),
      .INT_W         (INT_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .abrirComporta (abrirComporta),
      .emergencia    (emergencia),
      .posicao       (posicao),
      .aberta        (aberta),
      .fechada       (fechada),
      .movendo       (movendo),
      .alarme        (alarme),
      .dbEstado      (dbEstado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: gate activity plus cycles left in the current wait.
   typedef enum int {M_IDLE, M_PREP, M_OSTEP, M_OWAIT, M_OPENED,
                     M_CSTEP, M_CWAIT, M_ESTEP, M_EWAIT, M_LOCK} mode_t;
   mode_t m_mode;
   int    m_pos;
   int    m_left;

   // {dbEstado[3:0], posicao[1:0], aberta, fechada, movendo, alarme}
   logic [9:0] exp_q[$];

   function automatic int code_of(input mode_t m);
      case (m)
         M_IDLE:   return 0;
         M_PREP:   return 1;
         M_OSTEP:  return 2;
         M_OWAIT:  return 3;
         M_OPENED: return 4;
         M_CSTEP:  return 5;
         M_CWAIT:  return 6;
         M_ESTEP:  return 7;
         M_EWAIT:  return 8;
         default:  return 9;
      endcase
   endfunction

   function automatic logic [9:0] expect_now();
      logic mv;
      logic al;
      mv = !(m_mode inside {M_IDLE, M_PREP, M_OPENED, M_LOCK});
      al = (m_mode inside {M_ESTEP, M_EWAIT, M_LOCK});
      return {4'(code_of(m_mode)), 2'(m_pos), m_mode == M_OPENED,
              m_pos == 0, mv, al};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_pos  = 0;
      m_left = 0;
   endtask

   task automatic model_step(input logic ab, input logic em);
      case (m_mode)
         M_IDLE:   if (em) m_mode = M_LOCK; else if (ab) m_mode = M_PREP;
         M_PREP:   m_mode = M_OSTEP;
         M_OSTEP:  begin
            if (m_pos < N_POS - 1) m_pos++;
            m_mode = M_OWAIT; m_left = INTERVAL;
         end
         M_OWAIT: begin
            if (em) m_mode = M_ESTEP;
            else if (m_left == 1) begin
               if (m_pos == N_POS - 1) m_mode = M_OPENED;
               else if (!ab) m_mode = M_CSTEP;
               else m_mode = M_OSTEP;
            end else m_left--;
         end
         M_OPENED: if (em) m_mode = M_ESTEP; else if (!ab) m_mode = M_CSTEP;
         M_CSTEP: begin
            if (m_pos > 0) m_pos--;
            m_mode = M_CWAIT; m_left = INTERVAL;
         end
         M_CWAIT: begin
            if (em) m_mode = M_ESTEP;
            else if (m_left == 1) begin
               if (m_pos == 0) m_mode = M_IDLE;
               else if (ab) m_mode = M_OSTEP;
               else m_mode = M_CSTEP;
            end else m_left--;
         end
         M_ESTEP: begin
            if (m_pos > 0) m_pos--;
            m_mode = M_EWAIT; m_left = FAST;
         end
         M_EWAIT: begin
            if (m_left == 1) m_mode = (m_pos == 0) ? M_LOCK : M_ESTEP;
            else m_left--;
         end
         default:  if (!em && !ab) m_mode = M_IDLE;
      endcase
   endtask

   // One clock of stimulus: drive on the falling edge, queue what the next
   // rising edge must produce.
   task automatic cyc(input logic ab, input logic em, input logic rs);
      @(negedge clock);
      abrirComporta = ab;
      emergencia    = em;
      reset         = rs;
      if (!rs) model_reset();
      else model_step(ab, em);
      exp_q.push_back(expect_now());
   endtask

   task automatic chk(input string nm, input int got, input int req);
      n_vec++;
      if (got != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d at t=%0t", nm, got, req, $time);
      end
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   // Monitor: every rising edge presents a new output vector.
   initial begin
      logic [9:0] e;
      logic [9:0] g;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {dbEstado, posicao, aberta, fechada, movendo, alarme};
            n_vec++;
            if (g !== e) begin
               n_err++;
               $display("FAIL scoreboard t=%0t: got db=%0d pos=%0d a/f/m/al=%b, required db=%0d pos=%0d a/f/m/al=%b",
                        $time, g[9:6], g[5:4], g[3:0], e[9:6], e[5:4], e[3:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete, required finish");
      $fatal(1);
   end

   initial begin
      logic ab;
      logic em;
      logic rs;
      abrirComporta = 1'b0;
      emergencia    = 1'b0;
      reset         = 1'b0;
      model_reset();

      cyc(0, 0, 0);
      settle();
      chk("reset_db", int'(dbEstado), 0);
      chk("reset_pos", int'(posicao), 0);
      chk("reset_fechada", int'(fechada), 1);
      chk("reset_alarme", int'(alarme), 0);
      chk("reset_movendo", int'(movendo), 0);
      cyc(0, 0, 0);

      // Full open with fixed timeline.
      for (int k = 1; k <= 17; k++) begin
         cyc(1, 0, 1);
         settle();
         if (k == 1)  chk("open_prepara", int'(dbEstado), 1);
         if (k == 2)  chk("open_abre_passo", int'(dbEstado), 2);
         if (k == 3)  chk("open_pos1", int'(posicao), 1);
         if (k == 8)  chk("open_pos2", int'(posicao), 2);
         if (k == 13) chk("open_pos3", int'(posicao), 3);
         if (k == 17) begin
            chk("open_aberta", int'(aberta), 1);
            chk("open_db", int'(dbEstado), 4);
            chk("open_movendo", int'(movendo), 0);
         end
      end

      // Close fully from ABERTA.
      for (int k = 0; k < 20; k++) cyc(0, 0, 1);
      settle();
      chk("close_db", int'(dbEstado), 0);
      chk("close_fechada", int'(fechada), 1);

      // Reversal while waiting at position 2.
      for (int k = 0; k < 9; k++) cyc(1, 0, 1);
      for (int k = 0; k < 25; k++) cyc(0, 0, 1);
      settle();
      chk("reversal_pos", int'(posicao), 0);
      chk("reversal_db", int'(dbEstado), 0);

      // Emergency from ABERTA, held open request keeps TRAVADA.
      for (int k = 0; k < 17; k++) cyc(1, 0, 1);
      cyc(1, 1, 1);
      settle();
      chk("emerg_alarme", int'(alarme), 1);
      for (int k = 0; k < 11; k++) cyc(1, 1, 1);
      settle();
      chk("emerg_travada", int'(dbEstado), 9);
      for (int k = 0; k < 3; k++) cyc(1, 0, 1);
      settle();
      chk("travada_hold", int'(dbEstado), 9);
      cyc(0, 0, 1);
      settle();
      chk("travada_release", int'(dbEstado), 0);

      // Emergency and open together in INICIAL.
      cyc(1, 1, 1);
      cyc(1, 1, 1);
      settle();
      chk("both_db", int'(dbEstado), 9);
      chk("both_pos", int'(posicao), 0);
      chk("both_alarme", int'(alarme), 1);
      cyc(0, 0, 1);

      // Asynchronous reset during ESPERA_FECHA at position 2.
      for (int k = 0; k < 17; k++) cyc(1, 0, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      settle();
      chk("pre_reset_db", int'(dbEstado), 6);
      chk("pre_reset_pos", int'(posicao), 2);
      #1 reset = 1'b0;
      #1;
      chk("async_reset_pos", int'(posicao), 0);
      chk("async_reset_db", int'(dbEstado), 0);
      chk("async_reset_fechada", int'(fechada), 1);
      model_reset();
      cyc(0, 0, 0);

      // Randomised operation.
      ab = 1'b0;
      em = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(11) == 0) ab = ~ab;
         if ($urandom_range(49) == 0) em = ~em;
         rs = ($urandom_range(499) != 0);
         cyc(ab, em, rs);
      end

      cyc(0, 0, 1);
      settle();
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
